uart_rx_frame: RTL and testbench

Standalone UART receiver that decodes frames produced by the team's UART transmitter: 5–8 data bits LSB-first, optional parity, 1 or 2 stop bits. It uses 16x oversampling with 3-sample majority voting, and rejects glitches on the start bit. Received characters are presented on a valid/ready interface with parity and framing error flags, overrun detection and RTS flow control. It sits between the serial pin (already pulled to idle-high) and the host-side consumer.

---
 rtl/uart_rx_frame.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_frame.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// Purpose: 16x-oversampled UART receiver (5-8 data bits, optional parity, 1/2 stop) with glitch-rejecting start detection.
// Latency: rx_valid rises 1 clk after the tick at phase 9 of the last stop bit.
// Backpressure: one-character holding register; a frame completing while it is full is dropped and flagged by overrun; rts_n mirrors rx_valid.
// Ports: clk/reset (async, active-high); rx serial in; data_bit_num/stop_bit_num/parity_en/parity_type frame format;
//        rx_ready consumer accept; rx_data/rx_valid/parity_error/framing_error held character; overrun drop pulse; rts_n flow control.
module uart_rx_frame #(
  parameter int CLK_DIV = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic [1:0] data_bit_num,
  input  logic       stop_bit_num,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       overrun,
  output logic       rts_n
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t       state, state_n;
  logic [CW-1:0] div_cnt;
  logic         tick;
  logic         rx_m, rx_s;
  logic [3:0]   phase;
  logic         s7, s8, maj;
  logic [2:0]   bit_idx;
  logic         stop_idx;
  logic         armed;
  logic [7:0]   shreg;
  logic [1:0]   cfg_nb;
  logic         cfg_sb, cfg_pe, cfg_pt;
  logic         perr, ferr;
  logic         mid, eob, last_data, done;

  assign tick      = (div_cnt == CW'(CLK_DIV - 1));
  assign mid       = tick && (phase == 4'd9);
  assign eob       = tick && (phase == 4'd15);
  // Last data bit index is N-1 = 4 + data_bit_num.
  assign last_data = (bit_idx == {1'b1, cfg_nb});
  // Sample at phase 9 is taken live from rx_s, so the vote uses it directly.
  assign maj       = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + CW'(1);
      rx_m    <= rx;
      rx_s    <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    done    = 1'b0;
    case (state)
      S_IDLE:   if (tick && armed && !rx_s) state_n = S_START;
      S_START:  begin
        if (mid && maj)  state_n = S_IDLE;   // start bit did not hold low: glitch
        else if (eob)    state_n = S_DATA;
      end
      S_DATA:   if (eob && last_data) state_n = cfg_pe ? S_PARITY : S_STOP;
      S_PARITY: if (eob) state_n = S_STOP;
      S_STOP:   begin
        if (mid && (stop_idx == cfg_sb)) begin
          done    = 1'b1;
          state_n = S_IDLE;
        end
      end
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase    <= '0;
      s7       <= 1'b1;
      s8       <= 1'b1;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      armed    <= 1'b0;
      shreg    <= '0;
      cfg_nb   <= '0;
      cfg_sb   <= 1'b0;
      cfg_pe   <= 1'b0;
      cfg_pt   <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      if (state_n != state)                phase <= '0;
      else if (tick && (state != S_IDLE))  phase <= phase + 4'd1;

      if (tick && (state != S_IDLE) && (phase == 4'd7)) s7 <= rx_s;
      if (tick && (state != S_IDLE) && (phase == 4'd8)) s8 <= rx_s;

      // A line still low when a frame ends must go high before the next start counts.
      if ((state != S_IDLE) && (state_n == S_IDLE)) armed <= rx_s;
      else if ((state == S_IDLE) && rx_s)           armed <= 1'b1;

      case (state)
        S_START: if (mid && !maj) begin
          cfg_nb   <= data_bit_num;
          cfg_sb   <= stop_bit_num;
          cfg_pe   <= parity_en;
          cfg_pt   <= parity_type;
          shreg    <= '0;
          perr     <= 1'b0;
          ferr     <= 1'b0;
          bit_idx  <= '0;
          stop_idx <= 1'b0;
        end
        S_DATA: begin
          if (mid) shreg[bit_idx] <= maj;
          if (eob && !last_data) bit_idx <= bit_idx + 3'd1;
        end
        S_PARITY: if (mid) perr <= (maj != (cfg_pt ? ^shreg : ~^shreg));
        S_STOP: begin
          if (mid && !maj) ferr <= 1'b1;
          if (eob) stop_idx <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      rts_n         <= 1'b1;
    end else begin
      overrun <= 1'b0;
      rts_n   <= rx_valid;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data       <= shreg;
          parity_error  <= perr;
          framing_error <= ferr | ~maj;  // include the stop bit being decided now
          rx_valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
module tb_uart_rx_frame;

  localparam int CLK_DIV = 4;
  localparam int BIT     = 16 * CLK_DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [1:0] data_bit_num;
  logic       stop_bit_num, parity_en, parity_type, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, parity_error, framing_error, overrun, rts_n;

  uart_rx_frame #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .data_bit_num(data_bit_num), .stop_bit_num(stop_bit_num),
    .parity_en(parity_en), .parity_type(parity_type), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .parity_error(parity_error),
    .framing_error(framing_error), .overrun(overrun), .rts_n(rts_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
  int   n_ovr = 0, exp_ovr = 0, n_rx = 0, n_vcyc = 0;
  logic prev_valid = 1'b0;
  logic prev_rst   = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Consumer ready driver
  initial begin
    rx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       rx_ready = 1'b0;
        1:       rx_ready = 1'b1;
        default: rx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      if (!prev_rst) check("rts_n_follows_valid", {31'd0, rts_n}, {31'd0, prev_valid});
      if (overrun)  n_ovr++;
      if (rx_valid) n_vcyc++;
      if (rx_valid && rx_ready) begin
        n_rx++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: got data %0h, required no frame", rx_data);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", {24'd0, rx_data}, {24'd0, e.d});
          check("parity_error", {31'd0, parity_error}, {31'd0, e.pe});
          check("framing_error", {31'd0, framing_error}, {31'd0, e.fe});
        end
      end
    end
    prev_valid = rx_valid;
    prev_rst   = reset;
  end

  task automatic bit_wait(input int nbits);
    repeat (nbits * BIT) @(posedge clk);
    #1;
  endtask

  // Builds a frame from its format and, if push, records what the consumer should see.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] nb, input logic pe,
                            input logic pt, input logic sb, input logic bad_par,
                            input logic bad_stop, input int bad_idx, input int hold_low,
                            input logic scramble, input logic push);
    int         n;
    logic [7:0] dm;
    logic       par;
    exp_t       e;
    n  = 5 + int'(nb);
    dm = '0;
    for (int i = 0; i < n; i++) dm[i] = d[i];
    par = (pt ? ^dm : ~^dm) ^ bad_par;
    if (push) begin
      e.d  = dm;
      e.pe = pe & bad_par;
      e.fe = bad_stop;
      exp_q.push_back(e);
    end
    data_bit_num = nb; stop_bit_num = sb; parity_en = pe; parity_type = pt;
    rx = 1'b0;
    bit_wait(1);
    if (scramble) begin
      data_bit_num = 2'($urandom_range(0, 3));
      stop_bit_num = 1'($urandom_range(0, 1));
      parity_en    = 1'($urandom_range(0, 1));
      parity_type  = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < n; i++) begin
      rx = dm[i];
      bit_wait(1);
    end
    if (pe) begin
      rx = par;
      bit_wait(1);
    end
    for (int s = 0; s < (sb ? 2 : 1); s++) begin
      rx = !(bad_stop && (s == bad_idx));
      bit_wait(1);
    end
    if (hold_low > 0) begin
      rx = 1'b0;
      bit_wait(hold_low);
    end
    rx = 1'b1;
    bit_wait(2);
  endtask

  task automatic wait_accept(input string name);
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rx_valid && rx_ready) break;
    end
    if (k == 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no acceptance in 50 cycles, required acceptance", name);
    end
  endtask

  initial begin
    int rx0;
    reset = 1'b1; rx = 1'b1;
    data_bit_num = 2'b11; stop_bit_num = 1'b0; parity_en = 1'b0; parity_type = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_parity_error", {31'd0, parity_error}, 32'd0);
    check("rst_framing_error", {31'd0, framing_error}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_rts_n", {31'd0, rts_n}, 32'd1);
    @(posedge clk); #2;
    reset = 1'b0;
    bit_wait(2);

    // 8N1 0xA5, single-cycle valid with ready high
    rx0 = n_vcyc;
    send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    check("a5_valid_cycles", n_vcyc - rx0, 32'd1);

    // 7E1 with wrong then correct parity
    send_frame(8'h35, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
    send_frame(8'h35, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);

    // 5 data bits, 2 stop, second stop low, then line held low
    rx0 = n_rx;
    send_frame(8'h15, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 10, 1'b0, 1'b1);
    check("held_low_frames", n_rx - rx0, 32'd1);
    send_frame(8'h0A, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);

    // Start-bit glitch of 4 ticks
    rx0 = n_rx;
    rx = 1'b0;
    repeat (4 * CLK_DIV) @(posedge clk);
    #1;
    rx = 1'b1;
    bit_wait(3);
    check("glitch_no_frame", n_rx - rx0, 32'd0);
    send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);

    // Overrun: second frame dropped while the first is held
    ready_mode = 0;
    bit_wait(1);
    send_frame(8'h11, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    send_frame(8'h22, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    exp_ovr++;
    @(negedge clk);
    check("ovr_held_valid", {31'd0, rx_valid}, 32'd1);
    check("ovr_held_data", {24'd0, rx_data}, 32'h11);
    check("ovr_pulses", n_ovr, exp_ovr);
    check("ovr_rts_n", {31'd0, rts_n}, 32'd1);
    ready_mode = 1;
    wait_accept("ovr");
    @(negedge clk);
    check("ovr_valid_drop", {31'd0, rx_valid}, 32'd0);
    @(negedge clk);
    check("ovr_rts_n_low", {31'd0, rts_n}, 32'd0);

    // Reset during data bit 3
    data_bit_num = 2'b11; stop_bit_num = 1'b0; parity_en = 1'b0;
    rx = 1'b0;
    bit_wait(1);
    rx = 1'b1; bit_wait(1);
    rx = 1'b1; bit_wait(1);
    rx = 1'b0; bit_wait(1);
    rx = 1'b1;
    repeat (BIT / 2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("mid_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("mid_rst_flags", {30'd0, parity_error, framing_error}, 32'd0);
    check("mid_rst_overrun", {31'd0, overrun}, 32'd0);
    check("mid_rst_rts_n", {31'd0, rts_n}, 32'd1);
    repeat (5) @(posedge clk);
    rx = 1'b1;
    #2;
    reset = 1'b0;
    bit_wait(2);
    send_frame(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);

    // Randomized formats, data, errors, mid-frame config changes and consumer stalls
    ready_mode = 2;
    for (int f = 0; f < 24; f++) begin
      logic sb;
      sb = 1'($urandom_range(0, 1));
      send_frame(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), sb, ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0), int'($urandom_range(0, 1)) & int'(sb), 0, 1'b1, 1'b1);
    end

    ready_mode = 1;
    for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    check("overrun_total", n_ovr, exp_ovr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
